// File: rtl/mips_fetch_pkg.sv
// Shared types and width defaults for the MIPS instruction fetch path.
// instr_mem uses the same width defaults so the address and data buses line up.
package mips_fetch_pkg;

  localparam int FETCH_ADDR_SIZE   = 15;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

endpackage : mips_fetch_pkg

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between fetch and decode.
// Flush beats load; with neither, the stage holds, or empties once its word is accepted.
module fetch_out_reg
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_SIZE   = FETCH_ADDR_SIZE,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic                   i_flush,
  input  logic                   i_ready,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_SIZE-1:0]   i_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_SIZE-1:0]   o_pc,
  output logic                   o_fire
);

  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_SIZE-1:0]   r_pc;

  // NOTE: every register here is reset, data included, because decode may sample
  // out_instr/out_pc straight out of reset; sequential state always uses <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_fire  = r_valid && i_ready;

endmodule : fetch_out_reg

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC and the start/halt FSM and counts
// accepted handshakes. Fetched words go to decode through fetch_out_reg.
module instr_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int                   ADDR_SIZE   = FETCH_ADDR_SIZE,
  parameter int                   INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         halt,
  input  logic                         redirect_valid,
  input  logic [ADDR_SIZE-1:0]         redirect_addr,
  output logic [ADDR_SIZE-1:0]         imem_addr,
  input  logic [INSTR_WIDTH-1:0]       imem_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [ADDR_SIZE-1:0]         out_pc,
  output logic                         running,
  output logic [FETCH_COUNT_WIDTH-1:0] fetch_count
);

  localparam logic [ADDR_SIZE-1:0]         PC_ONE    = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [FETCH_COUNT_WIDTH-1:0] COUNT_ONE = {{(FETCH_COUNT_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t                   r_state;
  fetch_state_t                   w_next_state;
  logic [ADDR_SIZE-1:0]           r_pc;
  logic                           r_running;
  logic [FETCH_COUNT_WIDTH-1:0]   r_fetch_count;
  logic                           w_out_valid;
  logic                           w_advance;
  logic                           w_load;
  logic                           w_fire;

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      FETCH_IDLE, FETCH_HALT: if (start && !halt) w_next_state = FETCH_RUN;
      FETCH_RUN:              if (halt)           w_next_state = FETCH_HALT;
      default:                w_next_state = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == FETCH_RUN);
    end
  end

  // A redirect outranks a normal fetch and empties the output stage.
  assign w_advance = !w_out_valid || out_ready;
  assign w_load    = (r_state == FETCH_RUN) && w_advance && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_addr;
    end else if (w_load) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  // A handshake on the flush edge still counts: decode took the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_fire) begin
      r_fetch_count <= r_fetch_count + COUNT_ONE;
    end
  end

  fetch_out_reg #(
    .ADDR_SIZE   (ADDR_SIZE),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_ready (out_ready),
    .i_instr (imem_instr),
    .i_pc    (r_pc),
    .o_valid (w_out_valid),
    .o_instr (out_instr),
    .o_pc    (out_pc),
    .o_fire  (w_fire)
  );

  assign imem_addr   = r_pc;
  assign out_valid   = w_out_valid;
  assign running     = r_running;
  assign fetch_count = r_fetch_count;

endmodule : instr_fetch_ctrl

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a scoreboard queue of expected out_pc values
// is drained by a monitor on every accepted handshake; control checks run inline.
module tb_instr_fetch_ctrl;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          halt;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          running;
  logic [31:0]   fetch_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q[$];

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .running        (running),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory image: every address maps to a distinct word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {1'b1, a, 1'b0, a};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every handshake must match the next queued PC and its memory word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got out_pc 0x%0h with empty scoreboard", out_pc);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        check("sb_out_pc", 32'(out_pc), 32'(e));
        check("sb_out_instr", out_instr, mem_word(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    #11 rst_n = 1'b1;
    step(2);
    check("idle_no_fetch", 32'(out_valid), 32'd0);

    // Streaming from address 0 with decode always ready.
    for (int i = 0; i <= 6; i++) exp_q.push_back(AW'(i));
    out_ready = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_running", 32'(running), 32'd1);
    check("start_imem_addr", 32'(imem_addr), 32'd0);
    check("start_no_valid_yet", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("stream_imem_addr", 32'(imem_addr), 32'(i));
      check("stream_out_pc", 32'(out_pc), 32'(i - 1));
    end
    check("count_after_3", fetch_count, 32'd3);
    step(2);
    check("pre_stall_out_pc", 32'(out_pc), 32'd5);

    // Stall with out_pc = 5.
    out_ready = 1'b0;
    repeat (4) begin
      step(1);
      check("stall_out_pc", 32'(out_pc), 32'd5);
      check("stall_imem_addr", 32'(imem_addr), 32'd6);
      check("stall_count", fetch_count, 32'd5);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step(1);
    check("release_out_pc", 32'(out_pc), 32'd6);
    step(1);
    check("pre_redir_out_pc", 32'(out_pc), 32'd7);
    out_ready = 1'b0;
    step(1);
    check("pre_redir_count", fetch_count, 32'd7);

    // Redirect discards stalled pc 7.
    exp_q.push_back(AW'(16'h0100));
    exp_q.push_back(AW'(16'h0101));
    redirect_valid = 1'b1; redirect_addr = AW'(16'h0100);
    step(1);
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(out_valid), 32'd0);
    check("redir_imem_addr", 32'(imem_addr), 32'h0100);
    check("redir_count_held", fetch_count, 32'd7);
    out_ready = 1'b1;
    step(1);
    check("redir_target_pc", 32'(out_pc), 32'h0100);
    check("redir_target_valid", 32'(out_valid), 32'd1);
    step(1);
    check("redir_next_pc", 32'(out_pc), 32'h0101);
    check("redir_count", fetch_count, 32'd8);

    // Redirect near the top of the address space; handshake on the flush edge counts.
    exp_q.push_back(AW'(16'h7FFE));
    exp_q.push_back(AW'(16'h7FFF));
    exp_q.push_back(AW'(16'h0000));
    exp_q.push_back(AW'(16'h0001));
    redirect_valid = 1'b1; redirect_addr = AW'(16'h7FFE);
    step(1);
    redirect_valid = 1'b0;
    check("wrap_flush_count", fetch_count, 32'd9);
    check("wrap_flush_valid", 32'(out_valid), 32'd0);
    step(1);
    check("wrap_pc_7ffe", 32'(out_pc), 32'h7FFE);
    step(1);
    check("wrap_pc_7fff", 32'(out_pc), 32'h7FFF);
    step(1);
    check("wrap_pc_0000", 32'(out_pc), 32'h0000);
    step(1);
    check("wrap_pc_0001", 32'(out_pc), 32'h0001);
    check("wrap_imem_addr", 32'(imem_addr), 32'd2);

    // Halt with a pending output.
    out_ready = 1'b0;
    step(1);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("halt_running", 32'(running), 32'd0);
    check("halt_held_valid", 32'(out_valid), 32'd1);
    check("halt_held_pc", 32'(out_pc), 32'd1);
    check("halt_count", fetch_count, 32'd12);
    step(1);
    check("halt_held_pc2", 32'(out_pc), 32'd1);
    out_ready = 1'b1;
    step(1);
    check("halt_drained_valid", 32'(out_valid), 32'd0);
    check("halt_drained_count", fetch_count, 32'd13);
    step(2);
    check("halt_no_fetch", 32'(out_valid), 32'd0);
    check("halt_imem_frozen", 32'(imem_addr), 32'd2);
    exp_q.push_back(AW'(2));
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    step(1);
    check("resume_out_pc", 32'(out_pc), 32'd2);
    step(1);
    check("resume_count", fetch_count, 32'd14);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_imem_addr", 32'(imem_addr), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_sb_empty", 32'(exp_q.size()), 32'd0);
    #3 rst_n = 1'b1;
    step(3);
    check("arst_idle_valid", 32'(out_valid), 32'd0);
    check("arst_idle_addr", 32'(imem_addr), 32'd0);

    // Redirect in IDLE loads only the PC; then redirect and halt together from RUN.
    redirect_valid = 1'b1; redirect_addr = AW'(16'h0055);
    step(1);
    redirect_valid = 1'b0;
    check("idle_redir_addr", 32'(imem_addr), 32'h0055);
    check("idle_redir_running", 32'(running), 32'd0);
    exp_q.push_back(AW'(16'h0055));
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("rh_out_pc", 32'(out_pc), 32'h0055);
    halt = 1'b1; redirect_valid = 1'b1; redirect_addr = AW'(16'h0020);
    step(1);
    halt = 1'b0; redirect_valid = 1'b0;
    check("rh_running", 32'(running), 32'd0);
    check("rh_imem_addr", 32'(imem_addr), 32'h0020);
    check("rh_valid", 32'(out_valid), 32'd0);
    check("rh_count", fetch_count, 32'd1);
    step(2);
    check("rh_frozen_addr", 32'(imem_addr), 32'h0020);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch_ctrl

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the word-addressed instruction memory (`instr_mem`, combinational read): owns the program counter and drives `imem_addr`.
- Registers each fetched word together with its PC into a valid/ready output stage that feeds decode.
- Supports start/halt control, branch/jump redirect with flush, and decode backpressure.
- Sits between `instr_mem` and the decode stage of the MIPS pipeline.

Parameters:
- ADDR_SIZE, 15, width of the word address into instr_mem; also the PC width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; leaves IDLE or HALTED and begins fetching.
- halt  input  1  one-cycle pulse; stops issuing new fetches.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_addr  input  ADDR_SIZE  target word address.
- imem_addr  output  ADDR_SIZE  address to instr_mem; equals the PC register (combinational from the register).
- imem_instr  input  INSTR_WIDTH  data from instr_mem, valid in the same cycle as imem_addr.
- out_valid  output  1  out_instr and out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the output when out_valid && out_ready.
- out_instr  output  INSTR_WIDTH  registered instruction.
- out_pc  output  ADDR_SIZE  address out_instr came from.
- running  output  1  high while state == RUN.
- fetch_count  output  32  number of accepted handshakes; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, state = IDLE.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - running = 0, fetch_count = 0.
- States: IDLE, RUN, HALTED (enum fetch_state_t).
  - IDLE: start -> RUN.
  - RUN: halt -> HALTED.
  - HALTED: start -> RUN.
  - Transitions take effect at the next edge.
  - start and halt in the same cycle: halt wins.
- advance = !out_valid || out_ready.
- In RUN with advance and no redirect, at the edge:
  - out_instr <= imem_instr, out_pc <= pc, out_valid <= 1.
  - pc <= pc + 1, wrapping from 2^ADDR_SIZE-1 to 0.
  - With out_ready held high, one instruction per cycle; first valid output one cycle after entering RUN.
- Stall (RUN, out_valid && !out_ready): pc, out_instr, out_pc and out_valid all hold unchanged.
- Redirect (any state, highest priority), at the edge:
  - pc <= redirect_addr, out_valid <= 0, regardless of out_ready. A held stalled instruction is discarded and not counted.
  - In RUN the target instruction reaches out_valid one cycle later (two edges after the redirect cycle).
  - In IDLE or HALTED only pc loads; the state is unchanged.
- Redirect and halt in the same cycle: both apply; pc = target, state HALTED.
- Halt with a pending output: out_valid and its data hold until accepted, then out_valid drops to 0. No new fetch occurs in HALTED.
- fetch_count increments on every edge where out_valid && out_ready, including the edge a redirect flushes the stage if the handshake completes that cycle.
- When out_valid is 0, out_instr and out_pc keep their last values; they are not cleared.
- running = (state == RUN), registered.
- rst_n asserted mid-operation: immediate return to the reset values with no clock needed; in-flight output is lost.

Decomposition:
- Package mips_fetch_pkg holds:
  - fetch_state_t enum {FETCH_IDLE, FETCH_RUN, FETCH_HALT};
  - localparam defaults for ADDR_SIZE and INSTR_WIDTH, shared with instr_mem.
- One sub-module, fetch_out_reg: the valid/ready output register with load, hold and flush inputs.
- The PC, the FSM and fetch_count live in instr_fetch_ctrl.

Test Plan:
- Reset, then start pulse, out_ready=1 -> imem_addr 0,1,2,3 on successive cycles; out_pc 0,1,2 with out_instr = mem[0..2]; fetch_count=3 after 3 accepts.
- out_ready=0 for 4 cycles while out_pc=5 -> out_pc stays 5, imem_addr stays 6, fetch_count frozen; release -> next out_pc=6.
- redirect_valid with redirect_addr=0x0100 while out_pc=7 is stalled -> out_valid=0 next cycle; then out_pc=0x0100, 0x0101; fetch_count does not count pc 7.
- redirect to 0x7FFE, run -> out_pc 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- halt while out_valid=1, out_ready=0 -> output held; after ready, out_valid=0, running=0, imem_addr frozen; start -> fetching resumes from the held pc.
- rst_n low mid-stream (async, between edges) -> out_valid=0, imem_addr=RESET_PC, running=0, fetch_count=0 immediately; no fetch until a new start.
